pattern_scan_ctrl: RTL
======================

Name: pattern_scan_ctrl

Overview:
Run controller for the serial sequence detector datapath on the 1-bit `w` stream.
- Holds a programmable pattern: length, overlap mode, target match count and a no-match timeout.
- Arms detection on `start`, qualifies input bits with `w_valid` and pulses `z` on each match.
- Counts matches, then stops with `done` on target reached, or with `timed_out` on timeout.
- Sits between the test/host sequencer and the serial bit source; replaces hand-driven detector runs.

Parameters:
- PAT_W, 4: maximum pattern length in bits.
- CNT_W, 8: width of the match counter and the target count.
- TO_W, 8: width of the timeout counter.
- LEN_W, $clog2(PAT_W)+1: localparam, width of the pattern-length field.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  config write strobe; accepted only in IDLE or DONE, ignored while busy.
- cfg_pattern  in  PAT_W  pattern; bit [len-1] is the first bit received.
- cfg_len  in  LEN_W  pattern length, legal 1..PAT_W.
- cfg_overlap  in  1  1 = overlapping detection, 0 = history cleared after each match.
- cfg_target  in  CNT_W  matches before done; 0 = unlimited.
- cfg_timeout  in  TO_W  max valid bits without a match; 0 = disabled.
- start  in  1  begin a run from IDLE or DONE.
- abort  in  1  stop a run and go to IDLE without done.
- w  in  1  serial data bit.
- w_valid  in  1  `w` is sampled this cycle.
- z  out  1  one-cycle match pulse.
- busy  out  1  high in RUN.
- done  out  1  level, high in DONE.
- timed_out  out  1  DONE was caused by timeout; valid while done=1.
- match_cnt  out  CNT_W  matches in the current or last run.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; z, busy, done, timed_out = 0; match_cnt = 0.
  - Config registers: pattern = 0, len = PAT_W, overlap = 1, target = 0, timeout = 0.
  - History, fill counter and timeout counter = 0.
  - Reset mid-run discards everything.
- Config latch: on cfg_we in IDLE or DONE, register all cfg_* fields.
  - cfg_len = 0 is stored as 1; cfg_len > PAT_W is stored as PAT_W.
- States:
  - IDLE: start → RUN.
  - RUN: abort → IDLE; target hit → DONE with timed_out = 0; timeout → DONE with timed_out = 1.
  - DONE: start → RUN; abort → IDLE.
  - start and abort in the same cycle: abort wins.
- Entering RUN: clear history, fill counter, match_cnt, timeout counter and timed_out.
- In RUN, on each w_valid cycle:
  - History shifts left with `w` into bit 0.
  - fill increments, saturating at PAT_W.
  - Match condition: fill (including this bit) ≥ len AND the newest len bits equal pattern[len-1:0].
- Match latency: z is registered, high exactly one cycle, the cycle after the matching bit's w_valid.
  - match_cnt updates in the same cycle as z.
  - match_cnt saturates at all-ones when target = 0.
- Overlap = 0: on a match, fill resets to 0, so no bit is reused by a later match.
- Timeout:
  - The counter increments per valid bit and resets to 0 on a match.
  - When it reaches cfg_timeout (nonzero), go to DONE.
  - Match and timeout on the same bit: match wins and the counter resets.
- Target: when match_cnt reaches cfg_target (nonzero), go to DONE in the cycle z asserts; busy drops that cycle.
- w_valid in IDLE/DONE is ignored: no z, no counter change.
- w_valid low in RUN: no state change, no timeout progress.

Decomposition:
- Shared header `pattern_scan_defs.vh`: state encodings (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) and default config constants.
- One natural sub-module, `pattern_match_core`, containing:
  - the history shift register and fill counter;
  - the length-masked compare;
  - a combinational `hit` output and a `clr` input (run start / non-overlap clear).
- The FSM, counters and config registers stay in the top level.

Test Plan:
- Reset mid-run: assert rst_n=0 during RUN → all outputs 0 immediately; after release, the stored config is back to defaults.
- Overlap run: pattern=3'b101, len=3, overlap=1, target=0, timeout=0; start; feed valid bits 0,1,0,1,0,1,0,1,1 → z pulses one cycle after bits 4, 6 and 8; match_cnt=3; busy stays high.
- Non-overlap run: same stream with overlap=0 → z after bits 4 and 8 only; match_cnt=2.
- Target stop: target=2, overlap=1, same stream → done after bit 6 with match_cnt=2 and timed_out=0; bits 7–9 ignored, no further z.
- Timeout, then restart:
  - pattern=4'b1111, len=4, timeout=5; feed 0,1,0,1,0 → done and timed_out=1 after bit 5, match_cnt=0.
  - cfg_we in DONE is accepted; start clears timed_out.
- Gaps and control edges:
  - w_valid gaps in RUN → no timeout progress.
  - start+abort in the same cycle → IDLE.
  - cfg_we in RUN → ignored; the config read back is unchanged.
  - cfg_len=0 behaves as len 1: pattern bit 0 = 1 gives a z on every valid 1.

Source files
------------

// File: rtl/pattern_scan_ctrl_pkg.sv
// pattern_scan_ctrl_pkg
//   Shared definitions for the pattern scan controller: run-state encoding
//   and the configuration values loaded at reset.
package pattern_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Reset-time configuration; the pattern length default is PAT_W and is
  // applied in the top level where PAT_W is known.
  localparam logic DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/pattern_match_core.sv
// pattern_match_core
//   Serial history register, fill counter and length-masked compare.
//   Ports:
//     clk, rst_n  - clock, async active-low reset
//     clr         - clear history and fill (run start or non-overlap match)
//     shift       - a qualified bit is present on w this cycle
//     w           - serial data bit
//     pattern     - reference pattern, bit [len-1] is oldest
//     len         - active pattern length, 1..PAT_W (already clamped)
//     hit         - combinational: the bit on w completes a match
module pattern_match_core #(
  parameter int PAT_W = 4,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift,
  input  logic             w,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             hit
);

  logic [PAT_W-1:0] hist_q, hist_d, hist_new, mask;
  logic [LEN_W-1:0] fill_q, fill_d, fill_inc;

  always_comb begin
    hist_new = {hist_q[PAT_W-2:0], w};
    fill_inc = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
    for (int i = 0; i < PAT_W; i++) mask[i] = (i < int'(len));
    // fill_inc counts the current bit, so a match can complete on it.
    hit = shift && (fill_inc >= len) && (((hist_new ^ pattern) & mask) == '0);
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift) begin
      hist_d = hist_new;
      fill_d = fill_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl
//   Run controller around the serial pattern detector. Holds the pattern
//   configuration, arms on start, pulses z per match, and stops on target
//   count (done) or on a no-match timeout (done + timed_out).
//   Ports:
//     clk, rst_n              - clock, async active-low reset
//     cfg_we, cfg_*           - config write, honoured in IDLE/DONE only
//     start, abort            - run control; abort has priority
//     w, w_valid              - serial bit stream and its qualifier
//     z                       - one-cycle match pulse (registered)
//     busy, done, timed_out   - run status
//     match_cnt               - matches in current or last run
module pattern_scan_ctrl
  import pattern_scan_ctrl_pkg::*;
#(
  parameter  int PAT_W = 4,
  parameter  int CNT_W = 8,
  parameter  int TO_W  = 8,
  localparam int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             start,
  input  logic             abort,
  input  logic             w,
  input  logic             w_valid,
  output logic             z,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic [CNT_W-1:0] match_cnt
);

  state_e           state_q, state_d;
  logic             z_q, z_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [TO_W-1:0]  to_q, to_d, to_inc;

  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             overlap_q, overlap_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [TO_W-1:0]  timeout_q, timeout_d;

  logic shift, hit, run_start, core_clr;

  assign shift = (state_q == ST_RUN) && w_valid;
  // Non-overlap mode drops the history after a match so no bit is reused.
  assign core_clr = run_start || (hit && !overlap_q);

  pattern_match_core #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (core_clr),
    .shift   (shift),
    .w       (w),
    .pattern (pattern_q),
    .len     (len_q),
    .hit     (hit)
  );

  // Config latch with length clamped into 1..PAT_W.
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    target_d  = target_q;
    timeout_d = timeout_q;
    if (cfg_we && state_q != ST_RUN) begin
      pattern_d = cfg_pattern;
      overlap_d = cfg_overlap;
      target_d  = cfg_target;
      timeout_d = cfg_timeout;
      if (cfg_len == '0)                  len_d = LEN_W'(1);
      else if (cfg_len > LEN_W'(PAT_W))   len_d = LEN_W'(PAT_W);
      else                                len_d = cfg_len;
    end
  end

  always_comb begin
    state_d   = state_q;
    z_d       = 1'b0;
    cnt_d     = cnt_q;
    to_d      = to_q;
    tmo_d     = tmo_q;
    run_start = 1'b0;
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    to_inc    = (to_q == '1) ? to_q : to_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (!abort && start) run_start = 1'b1;
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b0;
        end else if (hit) begin
          // A match on the timeout bit wins: counter resets, run continues.
          z_d   = 1'b1;
          cnt_d = cnt_inc;
          to_d  = '0;
          if (target_q != '0 && cnt_inc == target_q) state_d = ST_DONE;
        end else if (shift) begin
          to_d = to_inc;
          if (timeout_q != '0 && to_inc == timeout_q) begin
            state_d = ST_DONE;
            tmo_d   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (abort) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b0;
        end else if (start) begin
          run_start = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (run_start) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      to_d    = '0;
      tmo_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      z_q       <= 1'b0;
      cnt_q     <= '0;
      to_q      <= '0;
      tmo_q     <= 1'b0;
      pattern_q <= '0;
      len_q     <= LEN_W'(PAT_W);
      overlap_q <= DEF_OVERLAP;
      target_q  <= '0;
      timeout_q <= '0;
    end else begin
      state_q   <= state_d;
      z_q       <= z_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      tmo_q     <= tmo_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      target_q  <= target_d;
      timeout_q <= timeout_d;
    end
  end

  assign z         = z_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign timed_out = tmo_q && done;
  assign match_cnt = cnt_q;

endmodule
